// File: rtl/axi_port_decode_pkg.sv
// Shared constants and rule type for the slave-port decoder and decode-error responder.
package axi_port_decode_pkg;

  localparam logic [1:0]  RESP_DECERR = 2'b11;
  localparam logic [31:0] ERR_DATA    = 32'hBADCAB1E;

  localparam int unsigned RULE_IDX_W  = 2;
  localparam int unsigned RULE_ADDR_W = 64;

  typedef struct packed {
    logic [RULE_IDX_W-1:0]  idx;
    logic [RULE_ADDR_W-1:0] start_addr;
    logic [RULE_ADDR_W-1:0] end_addr;
  } xbar_rule_t;

endpackage

// File: rtl/axi_port_decode_errslv_match.sv
// Address rule matcher: NoRules half-open range comparators, highest-index hit wins.
module addr_rule_match
  import axi_port_decode_pkg::*;
#(
  parameter int unsigned NoRules   = 4,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned IdxW      = 2
) (
  input  logic [NoRules*IdxW-1:0]      rule_idx_i,
  input  logic [NoRules*AddrWidth-1:0] rule_start_i,
  input  logic [NoRules*AddrWidth-1:0] rule_end_i,
  input  logic [AddrWidth-1:0]         addr_i,
  output logic                         hit_o,
  output logic [IdxW-1:0]              idx_o
);

  // Ascending scan so a later (higher-index) hit overrides earlier ones.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int unsigned k = 0; k < NoRules; k++) begin
      if ((addr_i >= rule_start_i[k*AddrWidth +: AddrWidth]) &&
          (addr_i <  rule_end_i[k*AddrWidth +: AddrWidth])) begin
        hit_o = 1'b1;
        idx_o = rule_idx_i[k*IdxW +: IdxW];
      end
    end
  end

endmodule

// File: rtl/axi_port_decode_errslv.sv
// Slave-port address decode plus built-in DECERR subordinate.
// Optional macro AXI_DECODE_DEFAULT_PORT_EN adds a default master port for misses.
module axi_port_decode_errslv
  import axi_port_decode_pkg::*;
#(
  parameter int unsigned NoMstPorts = 4,
  parameter int unsigned NoRules    = 4,
  parameter int unsigned AddrWidth  = 64,
  parameter int unsigned IdWidth    = 4,
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned MaxTrans   = 4,
  parameter int unsigned SelW       = $clog2(NoMstPorts + 1),
  parameter int unsigned IdxW       = $clog2(NoMstPorts)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
`ifdef AXI_DECODE_DEFAULT_PORT_EN
  input  logic                         en_default_mst_port_i,
  input  logic [IdxW-1:0]              default_mst_port_i,
`endif
  input  logic [NoRules*IdxW-1:0]      rule_idx_i,
  input  logic [NoRules*AddrWidth-1:0] rule_start_i,
  input  logic [NoRules*AddrWidth-1:0] rule_end_i,
  input  logic [AddrWidth-1:0]         aw_addr_i,
  input  logic [AddrWidth-1:0]         ar_addr_i,
  output logic [SelW-1:0]              aw_select_o,
  output logic [SelW-1:0]              ar_select_o,
  output logic                         aw_dec_error_o,
  output logic                         ar_dec_error_o,
  input  logic                         err_aw_valid_i,
  output logic                         err_aw_ready_o,
  input  logic [IdWidth-1:0]           err_aw_id_i,
  input  logic [7:0]                   err_aw_len_i,
  input  logic                         err_w_valid_i,
  output logic                         err_w_ready_o,
  input  logic                         err_w_last_i,
  output logic                         err_b_valid_o,
  input  logic                         err_b_ready_i,
  output logic [IdWidth-1:0]           err_b_id_o,
  output logic [1:0]                   err_b_resp_o,
  input  logic                         err_ar_valid_i,
  output logic                         err_ar_ready_o,
  input  logic [IdWidth-1:0]           err_ar_id_i,
  input  logic [7:0]                   err_ar_len_i,
  output logic                         err_r_valid_o,
  input  logic                         err_r_ready_i,
  output logic [IdWidth-1:0]           err_r_id_o,
  output logic [DataWidth-1:0]         err_r_data_o,
  output logic [1:0]                   err_r_resp_o,
  output logic                         err_r_last_o
);

  localparam int unsigned PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
  localparam int unsigned CntW = $clog2(MaxTrans + 1);

  function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxTrans - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---------------- address decode ----------------
  logic            w_aw_hit, w_ar_hit;
  logic [IdxW-1:0] w_aw_idx, w_ar_idx;
  logic [SelW-1:0] w_miss_sel;
  logic            w_miss_err;

  addr_rule_match #(
    .NoRules   (NoRules),
    .AddrWidth (AddrWidth),
    .IdxW      (IdxW)
  ) u_aw_match (
    .rule_idx_i   (rule_idx_i),
    .rule_start_i (rule_start_i),
    .rule_end_i   (rule_end_i),
    .addr_i       (aw_addr_i),
    .hit_o        (w_aw_hit),
    .idx_o        (w_aw_idx)
  );

  addr_rule_match #(
    .NoRules   (NoRules),
    .AddrWidth (AddrWidth),
    .IdxW      (IdxW)
  ) u_ar_match (
    .rule_idx_i   (rule_idx_i),
    .rule_start_i (rule_start_i),
    .rule_end_i   (rule_end_i),
    .addr_i       (ar_addr_i),
    .hit_o        (w_ar_hit),
    .idx_o        (w_ar_idx)
  );

`ifdef AXI_DECODE_DEFAULT_PORT_EN
  assign w_miss_sel = en_default_mst_port_i ? SelW'(default_mst_port_i) : SelW'(NoMstPorts);
  assign w_miss_err = !en_default_mst_port_i;
`else
  assign w_miss_sel = SelW'(NoMstPorts);
  assign w_miss_err = 1'b1;
`endif

  assign aw_select_o    = w_aw_hit ? SelW'(w_aw_idx) : w_miss_sel;
  assign ar_select_o    = w_ar_hit ? SelW'(w_ar_idx) : w_miss_sel;
  assign aw_dec_error_o = !w_aw_hit && w_miss_err;
  assign ar_dec_error_o = !w_ar_hit && w_miss_err;

  // ---------------- write path ----------------
  logic [IdWidth-1:0] r_wid_mem [MaxTrans];
  logic [PtrW-1:0]    r_wwr, r_wrd;
  logic [CntW-1:0]    r_wcnt;
  logic               r_wdone;
  logic               w_aw_push, w_w_hs, w_b_pop;
  logic               w_unused_awlen;

  assign w_unused_awlen = ^err_aw_len_i;

  assign err_aw_ready_o = rst_ni && (r_wcnt < CntW'(MaxTrans));
  assign err_w_ready_o  = rst_ni && (r_wcnt != '0) && !r_wdone;
  assign err_b_valid_o  = rst_ni && r_wdone;
  assign err_b_id_o     = r_wid_mem[r_wrd];
  assign err_b_resp_o   = RESP_DECERR;

  assign w_aw_push = err_aw_valid_i && err_aw_ready_o;
  assign w_w_hs    = err_w_valid_i && err_w_ready_o;
  assign w_b_pop   = err_b_valid_o && err_b_ready_i;

  always_ff @(posedge clk_i) begin
    if (w_aw_push) r_wid_mem[r_wwr] <= err_aw_id_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wwr   <= '0;
      r_wrd   <= '0;
      r_wcnt  <= '0;
      r_wdone <= 1'b0;
    end else begin
      if (w_aw_push) r_wwr <= ptr_next(r_wwr);
      if (w_b_pop)   r_wrd <= ptr_next(r_wrd);
      case ({w_aw_push, w_b_pop})
        2'b10:   r_wcnt <= r_wcnt + 1'b1;
        2'b01:   r_wcnt <= r_wcnt - 1'b1;
        default: r_wcnt <= r_wcnt;
      endcase
      // W ready is low while done is set, so last-handshake and B-pop never coincide.
      if (w_w_hs && err_w_last_i) r_wdone <= 1'b1;
      else if (w_b_pop)           r_wdone <= 1'b0;
    end
  end

  // ---------------- read path ----------------
  logic [IdWidth-1:0] r_rid_mem  [MaxTrans];
  logic [7:0]         r_rlen_mem [MaxTrans];
  logic [PtrW-1:0]    r_rwr, r_rrd;
  logic [CntW-1:0]    r_rcnt;
  logic [7:0]         r_beat;
  logic               w_ar_push, w_r_hs;

  assign err_ar_ready_o = rst_ni && (r_rcnt < CntW'(MaxTrans));
  assign err_r_valid_o  = rst_ni && (r_rcnt != '0);
  assign err_r_id_o     = r_rid_mem[r_rrd];
  assign err_r_resp_o   = RESP_DECERR;
  assign err_r_last_o   = (r_beat == r_rlen_mem[r_rrd]);

  assign w_ar_push = err_ar_valid_i && err_ar_ready_o;
  assign w_r_hs    = err_r_valid_o && err_r_ready_i;

  always_comb begin
    err_r_data_o = '0;
    for (int unsigned i = 0; i < DataWidth; i++) begin
      err_r_data_o[i] = ERR_DATA[i % 32];
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_ar_push) begin
      r_rid_mem[r_rwr]  <= err_ar_id_i;
      r_rlen_mem[r_rwr] <= err_ar_len_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rwr  <= '0;
      r_rrd  <= '0;
      r_rcnt <= '0;
      r_beat <= '0;
    end else begin
      if (w_ar_push) r_rwr <= ptr_next(r_rwr);
      if (w_r_hs) begin
        if (err_r_last_o) begin
          r_rrd  <= ptr_next(r_rrd);
          r_beat <= '0;
        end else begin
          r_beat <= r_beat + 1'b1;
        end
      end
      case ({w_ar_push, w_r_hs && err_r_last_o})
        2'b10:   r_rcnt <= r_rcnt + 1'b1;
        2'b01:   r_rcnt <= r_rcnt - 1'b1;
        default: r_rcnt <= r_rcnt;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_port_decode_errslv.sv
// Directed self-checking bench for the slave-port decoder and DECERR responder.
module tb_axi_port_decode_errslv;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   rule_idx;
  logic [255:0] rule_start, rule_end;
  logic [63:0]  aw_addr = '0, ar_addr = '0;
  logic [2:0]   aw_sel, ar_sel;
  logic         aw_err, ar_err;
  logic         aw_valid = 1'b0, aw_ready;
  logic [3:0]   aw_id = '0;
  logic [7:0]   aw_len = '0;
  logic         w_valid = 1'b0, w_ready, w_last = 1'b0;
  logic         b_valid, b_ready = 1'b0;
  logic [3:0]   b_id;
  logic [1:0]   b_resp;
  logic         ar_valid = 1'b0, ar_ready;
  logic [3:0]   ar_id = '0;
  logic [7:0]   ar_len = '0;
  logic         r_valid, r_ready = 1'b0;
  logic [3:0]   r_id;
  logic [63:0]  r_data;
  logic [1:0]   r_resp;
  logic         r_last;
`ifdef AXI_DECODE_DEFAULT_PORT_EN
  logic         en_dflt = 1'b0;
  logic [1:0]   dflt = '0;
`endif

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  axi_port_decode_errslv #(
    .NoMstPorts (4),
    .NoRules    (4),
    .AddrWidth  (64),
    .IdWidth    (4),
    .DataWidth  (64),
    .MaxTrans   (4)
  ) dut (
    .clk_i                 (clk),
    .rst_ni                (rst_n),
`ifdef AXI_DECODE_DEFAULT_PORT_EN
    .en_default_mst_port_i (en_dflt),
    .default_mst_port_i    (dflt),
`endif
    .rule_idx_i     (rule_idx),
    .rule_start_i   (rule_start),
    .rule_end_i     (rule_end),
    .aw_addr_i      (aw_addr),
    .ar_addr_i      (ar_addr),
    .aw_select_o    (aw_sel),
    .ar_select_o    (ar_sel),
    .aw_dec_error_o (aw_err),
    .ar_dec_error_o (ar_err),
    .err_aw_valid_i (aw_valid),
    .err_aw_ready_o (aw_ready),
    .err_aw_id_i    (aw_id),
    .err_aw_len_i   (aw_len),
    .err_w_valid_i  (w_valid),
    .err_w_ready_o  (w_ready),
    .err_w_last_i   (w_last),
    .err_b_valid_o  (b_valid),
    .err_b_ready_i  (b_ready),
    .err_b_id_o     (b_id),
    .err_b_resp_o   (b_resp),
    .err_ar_valid_i (ar_valid),
    .err_ar_ready_o (ar_ready),
    .err_ar_id_i    (ar_id),
    .err_ar_len_i   (ar_len),
    .err_r_valid_o  (r_valid),
    .err_r_ready_i  (r_ready),
    .err_r_id_o     (r_id),
    .err_r_data_o   (r_data),
    .err_r_resp_o   (r_resp),
    .err_r_last_o   (r_last)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int unsigned beats;
    int unsigned last_at;
    int unsigned n_last;

    // r3 has start==end and must never hit
    rule_idx   = {2'd2, 2'd3, 2'd1, 2'd0};
    rule_start = {64'h3000, 64'h1800, 64'h1000, 64'h0000};
    rule_end   = {64'h3000, 64'h1900, 64'h2000, 64'h1000};

    // reset state
    @(negedge clk);
    cyc();
    chk("rst_aw_ready", aw_ready, 0);
    chk("rst_ar_ready", ar_ready, 0);
    chk("rst_w_ready",  w_ready, 0);
    chk("rst_b_valid",  b_valid, 0);
    chk("rst_r_valid",  r_valid, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_aw_ready", aw_ready, 1);

    // decode
    aw_addr = 64'h1800; #1;
    chk("aw_1800_sel", aw_sel, 3); chk("aw_1800_err", aw_err, 0);
    ar_addr = 64'h0FFF; #1;
    chk("ar_0fff_sel", ar_sel, 0); chk("ar_0fff_err", ar_err, 0);
    aw_addr = 64'h2000; #1;
    chk("aw_2000_sel", aw_sel, 4); chk("aw_2000_err", aw_err, 1);
    aw_addr = 64'h3000; #1;
    chk("aw_3000_sel", aw_sel, 4); chk("aw_3000_err", aw_err, 1);
    ar_addr = 64'h1900; #1;
    chk("ar_1900_sel", ar_sel, 1);
    ar_addr = 64'h18FF; #1;
    chk("ar_18ff_sel", ar_sel, 3);
    ar_addr = 64'h0; #1;
    chk("ar_0_sel", ar_sel, 0);
`ifdef AXI_DECODE_DEFAULT_PORT_EN
    en_dflt = 1'b1; dflt = 2'd2; aw_addr = 64'h5000; #1;
    chk("dflt_en_sel", aw_sel, 2); chk("dflt_en_err", aw_err, 0);
    en_dflt = 1'b0; #1;
    chk("dflt_dis_sel", aw_sel, 4); chk("dflt_dis_err", aw_err, 1);
`endif

    // write burst: W offered before AW is held off
    @(negedge clk);
    w_valid = 1'b1; w_last = 1'b0; #1;
    chk("w_before_aw_ready", w_ready, 0);
    aw_valid = 1'b1; aw_id = 4'd5; aw_len = 8'd3; #1;
    chk("aw_ready", aw_ready, 1);
    chk("w_same_cycle_aw_ready", w_ready, 0);
    cyc();
    aw_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_last = (i == 3);
      #1;
      chk("w_beat_ready", w_ready, 1);
      chk("b_before_last", b_valid, 0);
      cyc();
    end
    w_valid = 1'b0; w_last = 1'b0; #1;
    chk("b_valid", b_valid, 1);
    chk("b_id", b_id, 5);
    chk("b_resp", b_resp, 2'b11);
    chk("w_ready_after_last", w_ready, 0);
    cyc();
    chk("b_held", b_valid, 1);
    chk("b_id_held", b_id, 5);
    b_ready = 1'b1;
    cyc();
    b_ready = 1'b0; #1;
    chk("b_popped", b_valid, 0);
    chk("w_ready_empty", w_ready, 0);

    // read burst with r_ready held high
    r_ready = 1'b1;
    ar_valid = 1'b1; ar_id = 4'd9; ar_len = 8'd2; #1;
    chk("ar_ready", ar_ready, 1);
    chk("r_before_ar", r_valid, 0);
    cyc();
    ar_valid = 1'b0; #1;
    for (int b = 0; b < 3; b++) begin
      chk("r_valid", r_valid, 1);
      chk("r_id", r_id, 9);
      chk("r_resp", r_resp, 2'b11);
      chk("r_data", r_data, 64'hBADCAB1EBADCAB1E);
      chk("r_last", r_last, (b == 2));
      cyc();
    end
    chk("r_done", r_valid, 0);

    // four outstanding reads fill the FIFO
    r_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      ar_valid = 1'b1; ar_id = 4'(i); ar_len = 8'd1; #1;
      chk("ar_fill_ready", ar_ready, 1);
      cyc();
    end
    ar_id = 4'd5; ar_len = 8'd0; #1;
    chk("ar_full", ar_ready, 0);
    chk("r_head_id", r_id, 1);
    chk("r_head_last0", r_last, 0);
    r_ready = 1'b1;
    cyc();
    chk("ar_full_beat1", ar_ready, 0);
    chk("r_head_last1", r_last, 1);
    cyc();
    chk("ar_ready_after_pop", ar_ready, 1);
    chk("r_next_id", r_id, 2);
    r_ready = 1'b0;
    cyc();
    ar_valid = 1'b0; #1;
    chk("ar_full_again", ar_ready, 0);

    // reset mid-burst
    r_ready = 1'b1;
    cyc();
    chk("mid_burst_valid", r_valid, 1);
    chk("mid_burst_last", r_last, 1);
    r_ready = 1'b0;
    rst_n = 1'b0; #1;
    chk("rst_r_valid_now", r_valid, 0);
    cyc();
    chk("rst_r_valid_next", r_valid, 0);
    rst_n = 1'b1; #1;
    chk("rel_ar_ready", ar_ready, 1);
    chk("rel_aw_ready", aw_ready, 1);
    r_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("no_stale_r", r_valid, 0);
      chk("no_stale_b", b_valid, 0);
      cyc();
    end

    // 256-beat burst: beat counter wraps and last lands on beat 255
    ar_valid = 1'b1; ar_id = 4'd3; ar_len = 8'd255; #1;
    chk("ar_long_ready", ar_ready, 1);
    cyc();
    ar_valid = 1'b0; #1;
    beats = 0; last_at = 0; n_last = 0;
    for (int c = 0; c < 300; c++) begin
      if (!r_valid) break;
      if (r_last) begin
        last_at = beats;
        n_last++;
      end
      beats++;
      cyc();
    end
    chk("long_beats", 64'(beats), 256);
    chk("long_last_at", 64'(last_at), 255);
    chk("long_n_last", 64'(n_last), 1);
    chk("long_done", r_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
